// File: rtl/frame_sequencer_if.sv
// Serial-to-word frame sequencer bus: serial bit inputs plus assembled-word and status outputs.
interface frame_sequencer_if #(
  parameter int WIDTH     = 10,
  parameter int MAX_WORDS = 16
);
  localparam int WC_W = $clog2(MAX_WORDS + 1);

  logic             frame_active;
  logic             bit_valid;
  logic             bit_in;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [WC_W-1:0]  word_count;
  logic             busy;
  logic             overrun;

  modport master (
    output frame_active, bit_valid, bit_in,
    input  data_out, go, finish, word_count, busy, overrun
  );

  modport slave (
    input  frame_active, bit_valid, bit_in,
    output data_out, go, finish, word_count, busy, overrun
  );
endinterface

// File: rtl/frame_sequencer.sv
// Assembles MSB-first serial bits into WIDTH-bit words per frame, flags the first word (go),
// signals frame end (finish) and counts words with a sticky overrun past MAX_WORDS.
//
// state   | meaning
// IDLE    | waiting for frame_active; outputs hold last frame's results
// COLLECT | shifting valid bits, emitting completed words
// DONE    | frame ended; one settle cycle, then finish for FINISH_CYCLES (skipped if empty)
module frame_sequencer #(
  parameter int WIDTH         = 10,
  parameter int MAX_WORDS     = 16,
  parameter int FINISH_CYCLES = 2
) (
  input logic              clock,
  input logic              reset,
  frame_sequencer_if.slave bus
);
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TM_W = (FINISH_CYCLES > 1) ? $clog2(FINISH_CYCLES + 1) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [WC_W-1:0] MAX_WC   = WC_W'(MAX_WORDS);
  localparam logic [TM_W-1:0] FIN_LOAD = TM_W'(FINISH_CYCLES);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic             go_q, go_d;
  logic             finish_q, finish_d;
  logic             ovr_q, ovr_d;
  logic [TM_W-1:0]  tmr_q, tmr_d;
  logic [WIDTH-1:0] assembled;

  assign assembled = {shift_q[WIDTH-2:0], bus.bit_in};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      wc_q      <= '0;
      go_q      <= 1'b0;
      finish_q  <= 1'b0;
      ovr_q     <= 1'b0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      wc_q      <= wc_d;
      go_q      <= go_d;
      finish_q  <= finish_d;
      ovr_q     <= ovr_d;
      tmr_q     <= tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    wc_d      = wc_q;
    go_d      = 1'b0;
    finish_d  = finish_q;
    ovr_d     = ovr_q;
    tmr_d     = tmr_q;

    case (state_q)
      IDLE: begin
        if (bus.frame_active) begin
          state_d   = COLLECT;
          shift_d   = '0;
          bit_cnt_d = '0;
          wc_d      = '0;
          ovr_d     = 1'b0;
        end
      end

      COLLECT: begin
        if (bus.bit_valid) begin
          shift_d = assembled;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (wc_q < MAX_WC) begin
              data_d = assembled;
              wc_d   = wc_q + WC_W'(1);
              go_d   = (wc_q == '0);
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        // A word completing on the closing cycle is still emitted above; leftover bits are dropped.
        if (!bus.frame_active) begin
          state_d = DONE;
          tmr_d   = FIN_LOAD;
        end
      end

      DONE: begin
        if (!finish_q) begin
          if (wc_q == '0) state_d = IDLE;
          else            finish_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TM_W'(1);
          if (tmr_q <= TM_W'(1)) begin
            finish_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.go         = go_q;
  assign bus.finish     = finish_q;
  assign bus.word_count = wc_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: driver queues expected words/frames, negedge monitor checks them.
module tb_frame_sequencer;
  localparam int WIDTH         = 10;
  localparam int MAX_WORDS     = 16;
  localparam int FINISH_CYCLES = 2;
  localparam int WC_W          = $clog2(MAX_WORDS + 1);

  logic clock = 1'b0;
  logic reset = 1'b0;

  frame_sequencer_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus ();

  frame_sequencer #(
    .WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .FINISH_CYCLES(FINISH_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    int               n;
    logic [WIDTH-1:0] last;
    logic             ovr;
  } frame_t;

  logic [WIDTH-1:0] exp_words[$];
  frame_t           exp_frames[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_emit_cyc = -10;

  int               model_wc = 0;
  logic             model_ovr = 1'b0;
  logic [WIDTH-1:0] model_last = '0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_total++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Monitor: a word is emitted exactly when word_count steps up by one.
  logic [WC_W-1:0] prev_wc = '0;
  logic            prev_fin = 1'b0;
  int              fin_len = 0;
  frame_t          fr;

  always @(negedge clock) begin
    cyc++;
    if (int'(bus.word_count) == int'(prev_wc) + 1) begin
      if (exp_words.size() == 0) fail_event("unexpected_word");
      else begin
        check("word_data", int'(bus.data_out), int'(exp_words.pop_front()));
        check("go_on_word", int'(bus.go), int'(bus.word_count == WC_W'(1)));
      end
      last_emit_cyc = cyc;
    end else if (bus.go) begin
      fail_event("spurious_go");
    end
    if (bus.finish && !prev_fin) begin
      if (exp_frames.size() == 0) fail_event("unexpected_finish");
      else begin
        fr = exp_frames.pop_front();
        check("fin_word_count", int'(bus.word_count), fr.n);
        check("fin_data", int'(bus.data_out), int'(fr.last));
        check("fin_overrun", int'(bus.overrun), int'(fr.ovr));
        check("fin_go_overlap", int'(bus.go), 0);
        check("fin_after_word", int'(cyc > last_emit_cyc), 1);
      end
      fin_len = 0;
    end
    if (bus.finish) fin_len++;
    if (!bus.finish && prev_fin) check("finish_len", fin_len, FINISH_CYCLES);
    prev_wc  = bus.word_count;
    prev_fin = bus.finish;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_active = 1'b1;
    bus.bit_valid    = 1'b0;
    model_wc  = 0;
    model_ovr = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int nbits, input logic drop_last);
    for (int i = 0; i < nbits; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = w[WIDTH-1-i];
      if (drop_last && i == nbits - 1) bus.frame_active = 1'b0;
      tick();
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_full(input logic [WIDTH-1:0] w, input logic drop_last);
    if (model_wc < MAX_WORDS) begin
      exp_words.push_back(w);
      model_wc++;
      model_last = w;
    end else begin
      model_ovr = 1'b1;
    end
    send_word(w, WIDTH, drop_last);
  endtask

  task automatic push_frame();
    frame_t f;
    f.n = model_wc; f.last = model_last; f.ovr = model_ovr;
    if (model_wc > 0) exp_frames.push_back(f);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) return;
      tick();
    end
    fail_event("timeout_busy");
  endtask

  task automatic end_frame(input logic dropped);
    push_frame();
    if (!dropped) begin
      bus.frame_active = 1'b0;
      bus.bit_valid    = 1'b0;
      tick();
    end
    wait_idle();
  endtask

  logic [WIDTH-1:0] w;
  logic             seen_fin;
  logic             left_done;

  initial begin
    bus.frame_active = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.bit_in       = 1'b0;
    tick(); tick();
    check("rst_data", int'(bus.data_out), 0);
    check("rst_go", int'(bus.go), 0);
    check("rst_finish", int'(bus.finish), 0);
    check("rst_word_count", int'(bus.word_count), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    reset = 1'b1;
    tick();

    // Two words; the second completes on the same cycle frame_active drops.
    start_frame();
    send_full(10'h155, 1'b0);
    send_full(10'h0AA, 1'b1);
    end_frame(1'b1);
    tick();
    check("idle_hold_data", int'(bus.data_out), 'h0AA);
    check("idle_hold_count", int'(bus.word_count), 2);

    // 15 bits: one word plus 5 discarded bits.
    start_frame();
    send_full(10'h3C5, 1'b0);
    send_word(10'h2B0, 5, 1'b0);
    end_frame(1'b0);

    // Empty and 7-bit frames: one DONE cycle, no go/finish.
    for (int n = 0; n <= 7; n += 7) begin
      start_frame();
      send_word(10'h1FF, n, 1'b0);
      bus.frame_active = 1'b0;
      tick();
      check("empty_busy_done", int'(bus.busy), 1);
      check("empty_finish", int'(bus.finish), 0);
      tick();
      check("empty_busy_idle", int'(bus.busy), 0);
      check("empty_count", int'(bus.word_count), 0);
      check("empty_data_hold", int'(bus.data_out), 'h3C5);
    end

    // 18 words into a 16-word frame.
    start_frame();
    for (int i = 1; i <= 18; i++) begin
      w = WIDTH'((i * 41 + 3) & 'h3FF);
      send_full(w, 1'b0);
    end
    end_frame(1'b0);
    check("ovr_sticky_idle", int'(bus.overrun), 1);
    check("ovr_count", int'(bus.word_count), 16);
    check("ovr_data_word16", int'(bus.data_out), 'h293);
    start_frame();
    check("ovr_cleared", int'(bus.overrun), 0);
    check("start_count_cleared", int'(bus.word_count), 0);
    send_full(10'h2A5, 1'b0);
    end_frame(1'b0);

    // Reset in the middle of a frame after three words.
    start_frame();
    send_full(10'h301, 1'b0);
    send_full(10'h0F3, 1'b0);
    send_full(10'h155, 1'b0);
    send_word(10'h3FF, 4, 1'b0);
    reset = 1'b0;
    bus.frame_active = 1'b0;
    #1;
    check("mid_rst_data", int'(bus.data_out), 0);
    check("mid_rst_count", int'(bus.word_count), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_finish", int'(bus.finish), 0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", int'(bus.busy), 0);
    tick();
    check("post_rst_still_idle", int'(bus.busy), 0);
    start_frame();
    send_full(10'h0F0, 1'b0);
    end_frame(1'b0);

    // frame_active back high right after frame end: DONE ignores it and bits.
    start_frame();
    send_full(10'h111, 1'b0);
    send_full(10'h222, 1'b0);
    push_frame();
    bus.frame_active = 1'b0;
    tick();
    bus.frame_active = 1'b1;
    seen_fin  = 1'b0;
    left_done = 1'b0;
    for (int k = 0; k < 20 && !left_done; k++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = k[0];
      tick();
      if (bus.finish) seen_fin = 1'b1;
      else if (seen_fin) left_done = 1'b1;
    end
    if (!left_done) fail_event("timeout_finish_drop");
    check("idle_after_finish", int'(bus.busy), 0);
    tick();
    bus.bit_valid = 1'b0;
    check("restart_from_idle", int'(bus.busy), 1);
    model_wc  = 0;
    model_ovr = 1'b0;
    send_full(10'h0CC, 1'b0);
    end_frame(1'b0);

    tick(); tick();
    check("words_drained", exp_words.size(), 0);
    check("frames_drained", exp_frames.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
